// File: rtl/timer_pkg.sv
// ============================================================================
// Module : timer_pkg
// Brief  : Shared widths, default clock rate and the 4-bit to packed-BCD decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package timer_pkg;

   localparam int BCD_W          = 8;
   localparam int PRESET_W       = 4;
   localparam int DEFAULT_CLK_HZ = 50_000_000;

   function automatic logic [BCD_W-1:0] bin4_to_bcd(input logic [PRESET_W-1:0] bin);
      logic [BCD_W-1:0] bcd;
      if (bin >= 4'd10) begin
         bcd = {4'd1, bin - 4'd10};
      end else begin
         bcd = {4'd0, bin};
      end
      return bcd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/timer_if.sv
// ============================================================================
// Module : timer_if
// Brief  : Preset / display bundle; timeout present only with TIMER_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface timer_if;
   import timer_pkg::*;

   logic [PRESET_W-1:0] set_timer;
   logic [BCD_W-1:0]    digit_time;

`ifdef TIMER_TIMEOUT_EN
   logic                timeout;

   modport master (output set_timer, input  digit_time, input  timeout);
   modport slave  (input  set_timer, output digit_time, output timeout);
`else
   modport master (output set_timer, input  digit_time);
   modport slave  (input  set_timer, output digit_time);
`endif

endinterface

`default_nettype wire

// File: rtl/timer_tick_gen.sv
// ============================================================================
// Module : tick_gen
// Brief  : Prescaler producing a one-cycle tick every TICK_DIV enabled clocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic clr,
   input  wire logic en,
   output logic      tick
);

   localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] prescaler;

   assign tick = en && !clr && (prescaler == LAST);

   // Held at zero while idle so a fresh countdown always gets a full period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
      end else if (clr || !en || prescaler == LAST) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/timer.sv
// ============================================================================
// Module : timer
// Brief  : Preset-reloading countdown timer with packed-BCD display output.
//          Define TIMER_TIMEOUT_EN to add the expiry flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module timer
   import timer_pkg::*;
#(
   parameter int CLK_HZ   = DEFAULT_CLK_HZ,
   parameter int TICK_DIV = CLK_HZ
) (
   input  wire logic clk,
   input  wire logic rst_n,
   timer_if.slave    bus
);

   logic [PRESET_W-1:0] set_q;
   logic [PRESET_W-1:0] count;
   logic                load;
   logic                tick;

   assign load = (bus.set_timer != set_q);

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (load),
      .en    (count != '0),
      .tick  (tick)
   );

   // A preset change always wins over a coincident tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_q <= '0;
         count <= '0;
      end else if (load) begin
         set_q <= bus.set_timer;
         count <= bus.set_timer;
      end else if (tick && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign bus.digit_time = bin4_to_bcd(count);

`ifdef TIMER_TIMEOUT_EN
   logic timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_q <= 1'b0;
      end else if (load) begin
         timeout_q <= 1'b0;
      end else if (tick && count == 4'd1) begin
         timeout_q <= 1'b1;
      end
   end

   assign bus.timeout = timeout_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer.sv
// ============================================================================
// Module : tb_timer
// Brief  : Directed plus randomized bench for timer against an elapsed-time model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timer;

   localparam int DIV = 4;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   // Reference state: last accepted preset and the cycle at which it was taken.
   int   cyc;
   int   mset;
   int   load_cyc;

   timer_if bus ();

   timer #(
      .CLK_HZ   (50_000_000),
      .TICK_DIV (DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic int exp_count();
      int el;
      el = cyc - load_cyc;
      if (mset == 0 || el >= mset * DIV) return 0;
      return mset - el / DIV;
   endfunction

   function automatic logic exp_timeout();
      return (mset != 0) && ((cyc - load_cyc) >= mset * DIV);
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_digit"}, bus.digit_time, to_bcd(exp_count()));
`ifdef TIMER_TIMEOUT_EN
      check({tag, "_timeout"}, {7'd0, bus.timeout}, {7'd0, exp_timeout()});
`endif
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      cyc++;
      if (rst_n && int'(bus.set_timer) != mset) begin
         mset     = int'(bus.set_timer);
         load_cyc = cyc;
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic steps(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic async_reset(input string tag);
      #4 rst_n = 1'b0;
      mset     = 0;
      load_cyc = cyc;
      #1;
      check({tag, "_rst_digit"}, bus.digit_time, 8'h00);
`ifdef TIMER_TIMEOUT_EN
      check({tag, "_rst_timeout"}, {7'd0, bus.timeout}, 8'h00);
`endif
      steps(2, {tag, "_in_rst"});
      rst_n = 1'b1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc = 0;
      mset = 0;
      load_cyc = 0;
      rst_n = 1'b0;
      bus.set_timer = 4'd0;

      #5;
      check("reset_digit", bus.digit_time, 8'h00);
      #20 rst_n = 1'b1;
      #75;                                   // t = 100 ns
      bus.set_timer = 4'd13;

      step("load13");
      check("load13_const", bus.digit_time, 8'h13);
      steps(3, "cd13");
      step("cd13_first_dec");
      check("dec12_const", bus.digit_time, 8'h12);
      steps(48, "cd13");
      check("expired_const", bus.digit_time, 8'h00);
`ifdef TIMER_TIMEOUT_EN
      check("expired_timeout_const", {7'd0, bus.timeout}, 8'h01);
`endif
      steps(6, "hold13");

      // Reload mid-countdown and confirm the prescaler restarts.
      bus.set_timer = 4'd10;
      steps(5, "cd10");
      check("at09_const", bus.digit_time, 8'h09);
      bus.set_timer = 4'd5;
      step("load5");
      check("load5_const", bus.digit_time, 8'h05);
      steps(3, "cd5_hold");
      check("cd5_still5_const", bus.digit_time, 8'h05);
      step("cd5_dec");
      check("cd5_to4_const", bus.digit_time, 8'h04);

      // Cancel path.
      bus.set_timer = 4'd0;
      step("cancel");
      check("cancel_const", bus.digit_time, 8'h00);
      steps(8, "idle");

      // Asynchronous reset mid-countdown, then reload of the unchanged preset.
      bus.set_timer = 4'd7;
      steps(6, "cd7");
      async_reset("mid7");
      step("reload7");
      check("reload7_const", bus.digit_time, 8'h07);
      steps(5, "cd7b");

      // Top preset, expiry hold, then a change re-arms.
      bus.set_timer = 4'd15;
      step("load15");
      check("load15_const", bus.digit_time, 8'h15);
      steps(62, "cd15");
      steps(10, "hold15");
      check("hold15_const", bus.digit_time, 8'h00);
      bus.set_timer = 4'd14;
      step("load14");
      check("load14_const", bus.digit_time, 8'h14);
`ifdef TIMER_TIMEOUT_EN
      check("load14_timeout_const", {7'd0, bus.timeout}, 8'h00);
`endif

      // Randomized preset changes and occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) bus.set_timer = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 149) == 0) async_reset("rand");
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
